// File: rtl/serial_frame_pkg.sv
// rtl/serial_frame_pkg.sv - shared types and constants for the serial frame receiver
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_e;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_frame_receiver_out_reg.sv
// rtl/serial_frame_receiver_out_reg.sv - one-entry valid/ready holding register (module serial_out_reg)
module serial_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             O_ready,
  output logic [WIDTH-1:0] O_data,
  output logic             O_valid,
  output logic             accepted
);

  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             load;

  // Room exists when empty or when the held word leaves on this same edge.
  assign accepted = !valid_q || O_ready;
  assign load     = push && accepted;

  // Load a new word, otherwise drop valid once the consumer takes the word.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      data_q  <= push_data;
      valid_q <= 1'b1;
    end else if (valid_q && O_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign O_data  = data_q;
  assign O_valid = valid_q;

endmodule

// File: rtl/serial_frame_receiver.sv
// rtl/serial_frame_receiver.sv - serial frame receiver top; MAGMA_INLINE_ASSERT_EN enables inline SVA
module serial_frame_receiver
  import serial_frame_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             I,
  output logic [WIDTH-1:0] O_data,
  output logic             O_valid,
  input  logic             O_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             push;
  logic             accepted;

  // Frame FSM: start detect, LSB-first data shift, stop-bit check.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    push        = 1'b0;
    case (state_q)
      IDLE: begin
        if (I == START_BIT) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        shift_d[cnt_q] = I;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = STOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        state_d = IDLE;
        if (I == STOP_BIT) begin
          push      = 1'b1;
          overrun_d = !accepted;
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, shift register and registered error pulses.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  serial_out_reg #(
    .WIDTH(WIDTH)
  ) u_out_reg (
    .CLK        (CLK),
    .ASYNCRESETN(ASYNCRESETN),
    .push       (push),
    .push_data  (shift_d),
    .O_ready    (O_ready),
    .O_data     (O_data),
    .O_valid    (O_valid),
    .accepted   (accepted)
  );

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q == DATA) || (state_q == STOP);

`ifdef MAGMA_INLINE_ASSERT_EN
  a_hold_stable: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
    O_valid && !O_ready |=> O_valid && $stable(O_data));
  a_overrun_full: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
    overrun |-> $past(O_valid));
  a_pulse_excl: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
    !(frame_err && overrun));
  a_stop_to_idle: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
    state_q == STOP |=> state_q == IDLE);
`else
`endif

endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb/tb_serial_frame_receiver.sv - directed table-driven bench for serial_frame_receiver
module tb_serial_frame_receiver;

  logic       CLK;
  logic       ASYNCRESETN;
  logic       I;
  logic [7:0] O_data;
  logic       O_valid;
  logic       O_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks;
  int failures;

  serial_frame_receiver #(.WIDTH(8)) dut (
    .CLK        (CLK),
    .ASYNCRESETN(ASYNCRESETN),
    .I          (I),
    .O_data     (O_data),
    .O_valid    (O_valid),
    .O_ready    (O_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       rd;
    logic       rs;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_fe;
    logic       exp_ov;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // rd: O_ready during start and data bits; rs: O_ready during the stop bit.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input logic rd, input logic rs);
    O_ready = rd;
    I = 1'b1;
    tick();
    check("busy_after_start", {31'd0, busy}, 32'd1);
    for (int b = 0; b < 8; b++) begin
      I = data[b];
      tick();
    end
    O_ready = rs;
    I = stop_bit;
    tick();
    I = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[2] = '{8'hC3, 1'b0, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0};
    vecs[3] = '{8'h12, 1'b1, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0};
    vecs[4] = '{8'h34, 1'b0, 1'b1, 1'b1, 1'b1, 8'h34, 1'b0, 1'b0};
    vecs[5] = '{8'h11, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0};
    vecs[6] = '{8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1};
    vecs[7] = '{8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
    vecs[8] = '{8'hAA, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0};

    ASYNCRESETN = 1'b0;
    I           = 1'b0;
    O_ready     = 1'b0;
    #3;
    check("rst_valid", {31'd0, O_valid}, 32'd0);
    check("rst_data", {24'd0, O_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fe", {31'd0, frame_err}, 32'd0);
    check("rst_ov", {31'd0, overrun}, 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    tick();
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Back-to-back frames from the table, each checked right after its stop edge.
    for (int v = 0; v < 9; v++) begin
      send_frame(vecs[v].data, vecs[v].stop_bit, vecs[v].rd, vecs[v].rs);
      check($sformatf("v%0d_valid", v), {31'd0, O_valid}, {31'd0, vecs[v].exp_valid});
      check($sformatf("v%0d_data", v), {24'd0, O_data}, {24'd0, vecs[v].exp_data});
      check($sformatf("v%0d_fe", v), {31'd0, frame_err}, {31'd0, vecs[v].exp_fe});
      check($sformatf("v%0d_ov", v), {31'd0, overrun}, {31'd0, vecs[v].exp_ov});
    end

    // Drain the last word; pulses must be gone.
    O_ready = 1'b1;
    tick();
    check("drain_valid", {31'd0, O_valid}, 32'd0);
    check("drain_ov", {31'd0, overrun}, 32'd0);
    check("drain_busy", {31'd0, busy}, 32'd0);

    // Latency: valid only on the stop edge, and for one cycle with O_ready=1.
    O_ready = 1'b1;
    I = 1'b1;
    tick();
    for (int b = 0; b < 8; b++) begin
      I = (b % 2 == 1) ? 1'b1 : 1'b0;
      tick();
      check("lat_early_valid", {31'd0, O_valid}, 32'd0);
    end
    I = 1'b0;
    tick();
    check("lat_valid", {31'd0, O_valid}, 32'd1);
    check("lat_data", {24'd0, O_data}, 32'hAA);
    tick();
    check("lat_one_cycle", {31'd0, O_valid}, 32'd0);

    // Overrun pulse width and later consumption of the held word.
    send_frame(8'h11, 1'b0, 1'b0, 1'b0);
    check("ovr_first_valid", {31'd0, O_valid}, 32'd1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0);
    check("ovr_pulse", {31'd0, overrun}, 32'd1);
    check("ovr_hold_data", {24'd0, O_data}, 32'h11);
    tick();
    check("ovr_pulse_end", {31'd0, overrun}, 32'd0);
    check("ovr_still_valid", {31'd0, O_valid}, 32'd1);
    check("ovr_still_data", {24'd0, O_data}, 32'h11);
    O_ready = 1'b1;
    tick();
    check("ovr_consumed", {31'd0, O_valid}, 32'd0);

    // Asynchronous reset mid-frame while a word is held.
    send_frame(8'h99, 1'b0, 1'b1, 1'b0);
    check("pre_rst_valid", {31'd0, O_valid}, 32'd1);
    O_ready = 1'b0;
    I = 1'b1;
    tick();
    for (int b = 0; b < 4; b++) begin
      I = 1'b1;
      tick();
    end
    check("mid_busy", {31'd0, busy}, 32'd1);
    #2;
    ASYNCRESETN = 1'b0;
    #1;
    check("arst_valid", {31'd0, O_valid}, 32'd0);
    check("arst_data", {24'd0, O_data}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_fe", {31'd0, frame_err}, 32'd0);
    check("arst_ov", {31'd0, overrun}, 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    I = 1'b0;
    ASYNCRESETN = 1'b1;
    tick();
    send_frame(8'h7E, 1'b0, 1'b1, 1'b1);
    check("post_rst_valid", {31'd0, O_valid}, 32'd1);
    check("post_rst_data", {24'd0, O_data}, 32'h7E);
    check("post_rst_fe", {31'd0, frame_err}, 32'd0);
    check("post_rst_ov", {31'd0, overrun}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
